adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one 17-bit signed adder between NREQ requesters, such as neuron partial-sum lanes in the digit-recognition datapath.
- Uses round-robin arbitration with valid/ready handshakes on both sides.
- Produces one registered 18-bit exact sum per cycle, tagged with the winning requester's index.
- Sits between the per-lane multiply/accumulate stages and the activation stage.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of the requester index; must satisfy 2**IDW >= NREQ.
- OPW, 17, operand width, signed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has an operand pair presented.
- req_a  in  NREQ*OPW  packed operand a; lane i occupies bits [i*OPW +: OPW].
- req_b  in  NREQ*OPW  packed operand b; same packing as req_a.
- req_ready  out  NREQ  one-hot grant; lane i's pair is consumed this cycle.
- res_valid  out  1  result register holds a sum.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  OPW+1  signed sum a+b.
- res_id  out  IDW  index of the requester that produced res_sum.
- busy_cycles  out  16  saturating count of cycles with res_valid=1 and res_ready=0.

Interface: one clock; reset is synchronous and active-high; the ports are clk and rst.

Behaviour:
- Reset: on rst=1 at a clock edge, all of the following load.
  - res_valid=0, res_sum=0, res_id=0.
  - Round-robin pointer ptr=0.
  - busy_cycles=0.
  - req_ready is combinational and is 0 while rst=1.
- Output register free: can_issue = !res_valid || res_ready.
- Grant selection (combinational):
  - When can_issue, the winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - req_ready has exactly one hot bit, at the winner; it is all-zero when no lane is valid or when can_issue=0.
  - req_ready never depends on res_valid through any path other than can_issue.
- Issue cycle: at the clock edge where a grant is made:
  - res_sum <= sext(a_w)+sext(b_w), computed exactly in OPW+1 bits. No overflow is possible: the range is -131072..131070.
  - res_id <= winner, res_valid <= 1.
  - ptr <= (winner+1) mod NREQ.
- Latency is one cycle from grant to res_valid. Throughput is one sum per cycle while res_ready=1.
- No grant with res_ready=1: res_valid <= 0. ptr is unchanged.
- Stall (res_valid=1, res_ready=0):
  - res_sum, res_id and res_valid hold; no grants are made; ptr holds.
  - busy_cycles increments, saturating at 16'hFFFF.
- Simultaneous res_ready=1 and a new grant: the old result retires and the new result loads in the same edge, with no bubble.
- Non-winning lanes: must hold their valid and operands stable until granted (requester obligation). The arbiter does not check this.
- Reset mid-operation: a pending result is discarded without handshake; rst takes priority over all updates.
- NREQ=1 degenerates to a registered adder with handshake; ptr stays 0.

Decomposition:
- Shared package: OPW, a function for the requester-index width, and the saturating counter maximum constant.
- Sub-module add_stage: purely combinational, two signed OPW inputs, OPW+1 output. The arbiter instantiates it once on the muxed operands.
- Round-robin selection is a function inside the arbiter; it is not a separate module.

Test Plan:
- Reset then idle: rst high for 2 cycles, all req_valid=0 → res_valid=0, req_ready=0, busy_cycles=0.
- Single lane: lane 2 with a=100, b=-250, res_ready=1 → req_ready=4'b0100 in cycle t; at t+1 res_valid=1, res_sum=-150, res_id=2.
- Round-robin fairness: all four lanes valid continuously, res_ready=1 → grant order 0,1,2,3,0,... with one result per cycle.
- Extremes: a=b=-65536 gives res_sum=-131072; a=b=65535 gives res_sum=131070; no wrap.
- Back-pressure: res_ready=0 for 5 cycles with lanes valid → req_ready=0, res_sum held, busy_cycles=5; then res_ready=1 resumes with the next lane after the last winner.
- Reset mid-stall: a result is pending and rst pulses → res_valid=0, ptr=0, and the next grant goes to lane 0 when lane 0 is valid.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants and helpers for the shared-adder round-robin arbiter.
package adder_share_arbiter_pkg;

    localparam int          OPW      = 17;
    localparam logic [15:0] BUSY_MAX = 16'hFFFF;

    // Smallest index width able to name every one of n requesters (at least 1 bit).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_add_stage.sv
// Combinational exact signed adder: two W-bit operands, W+1-bit sum, no wrap.
module add_stage
    import adder_share_arbiter_pkg::*;
#(
    parameter int W = OPW
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W:0]   sum_o
);

    // Sign-extend both operands by one bit so the sum is always exact.
    always_comb begin
        sum_o = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered signed adder among NREQ lanes,
// with valid/ready handshakes upstream and downstream.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idx_width(NREQ),
    parameter int OPW  = adder_share_arbiter_pkg::OPW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*OPW-1:0]    req_a,
    input  logic [NREQ*OPW-1:0]    req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [OPW:0]    res_sum,
    output logic [IDW-1:0]         res_id,
    output logic [15:0]            busy_cycles
);

    logic                  res_valid_q, res_valid_d;
    logic signed [OPW:0]   res_sum_q,   res_sum_d;
    logic [IDW-1:0]        res_id_q,    res_id_d;
    logic [IDW-1:0]        ptr_q,       ptr_d;
    logic [15:0]           busy_q,      busy_d;

    logic                  can_issue_s;
    logic                  grant_s;
    logic [IDW:0]          pick_s;
    logic [IDW-1:0]        winner_s;
    logic [IDW-1:0]        ptr_next_s;
    logic signed [OPW-1:0] a_w_s;
    logic signed [OPW-1:0] b_w_s;
    logic signed [OPW:0]   sum_s;

    // Returns {found, index} of the first valid lane scanning from p upward, wrapping at NREQ.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
        logic           found;
        logic [IDW-1:0] w;
        int             idx;
        found = 1'b0;
        w     = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(p) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && v[idx]) begin
                found = 1'b1;
                w     = IDW'(idx);
            end
        end
        return {found, w};
    endfunction

    // Grant selection and operand mux feeding the shared adder.
    always_comb begin
        can_issue_s = !res_valid_q || res_ready;
        pick_s      = rr_pick(req_valid, ptr_q);
        winner_s    = pick_s[IDW-1:0];
        grant_s     = can_issue_s && pick_s[IDW] && !rst;
        a_w_s       = req_a[winner_s*OPW +: OPW];
        b_w_s       = req_b[winner_s*OPW +: OPW];
        if (winner_s == IDW'(NREQ - 1)) begin
            ptr_next_s = {IDW{1'b0}};
        end else begin
            ptr_next_s = winner_s + {{(IDW-1){1'b0}}, 1'b1};
        end
    end

    add_stage #(.W(OPW)) u_add (
        .a_i   (a_w_s),
        .b_i   (b_w_s),
        .sum_o (sum_s)
    );

    // One-hot ready toward the winning lane only.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (grant_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Next-state for the result register, pointer and stall counter.
    always_comb begin
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        if (grant_s) begin
            res_valid_d = 1'b1;
            res_sum_d   = sum_s;
            res_id_d    = winner_s;
            ptr_d       = ptr_next_s;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
        if (res_valid_q && !res_ready && (busy_q != BUSY_MAX)) begin
            busy_d = busy_q + 16'd1;
        end else begin
            busy_d = busy_q;
        end
    end

    // State registers; reset discards any pending result without handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_sum_q   <= {(OPW+1){1'b0}};
            res_id_q    <= {IDW{1'b0}};
            ptr_q       <= {IDW{1'b0}};
            busy_q      <= 16'd0;
        end else begin
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_sum     = res_sum_q;
    assign res_id      = res_id_q;
    assign busy_cycles = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with hand-computed expectations.
module tb_adder_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [67:0] req_a;
    logic [67:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [17:0] res_sum;
    logic [1:0]  res_id;
    logic [15:0] busy_cycles;

    int checks;
    int errors;

    adder_share_arbiter #(.NREQ(4), .IDW(2), .OPW(17)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_id      (res_id),
        .busy_cycles (busy_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_lane(input int i, input logic [16:0] a, input logic [16:0] b);
        req_a[i*17 +: 17] = a;
        req_b[i*17 +: 17] = b;
    endtask

    // Lane i: a = 10*i+1, b = i, so sum = 11*i+1.
    task automatic load_rr_operands();
        for (int i = 0; i < 4; i++) begin
            set_lane(i, 17'(i*10 + 1), 17'(i));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 4'b0000; res_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 4'b1111; res_ready = 1'b1;
        load_rr_operands();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_in_rst: got %b exp %b", req_ready, 4'b0000); end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", res_valid); end
        checks++;
        if (busy_cycles !== 16'd0) begin errors++; $display("FAIL reset_busy: got %0d exp 0", busy_cycles); end
        checks++;
        if (res_sum !== 18'd0 || res_id !== 2'd0) begin errors++; $display("FAIL reset_sum_id: got %h/%0d exp 0/0", res_sum, res_id); end
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b0000;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b exp %b", req_ready, 4'b0000); end
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b exp 0", res_valid); end
    endtask

    task automatic test_single_lane();
        @(negedge clk);
        set_lane(2, 17'd100, -17'sd250);
        req_valid = 4'b0100; res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b exp %b", req_ready, 4'b0100); end
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 18'h3FF6A || res_id !== 2'd2)
            begin errors++; $display("FAIL single_result: got v=%b sum=%h id=%0d exp v=1 sum=3ff6a id=2", res_valid, res_sum, res_id); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_nogrant: got %b exp 0000", req_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b exp 0", res_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        load_rr_operands();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            req_valid = 4'b1111; res_ready = 1'b1;
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, req_ready, 4'(1 << (k % 4))); end
            @(posedge clk);
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_id !== 2'(k % 4) || res_sum !== 18'(11*(k % 4) + 1))
                begin errors++; $display("FAIL rr_result[%0d]: got v=%b id=%0d sum=%0d exp v=1 id=%0d sum=%0d", k, res_valid, res_id, res_sum, k % 4, 11*(k % 4) + 1); end
        end
    endtask

    task automatic test_extremes();
        @(negedge clk);
        set_lane(1, 17'h10000, 17'h10000);
        req_valid = 4'b0010; res_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (res_sum !== 18'h20000 || res_id !== 2'd1) begin errors++; $display("FAIL extreme_min: got %h id=%0d exp 20000 id=1", res_sum, res_id); end
        @(negedge clk);
        set_lane(1, 17'h0FFFF, 17'h0FFFF);
        @(posedge clk);
        #1;
        checks++;
        if (res_sum !== 18'h1FFFE || res_valid !== 1'b1) begin errors++; $display("FAIL extreme_max: got %h v=%b exp 1fffe v=1", res_sum, res_valid); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk);
    endtask

    task automatic test_back_pressure();
        load_rr_operands();
        @(negedge clk);
        req_valid = 4'b1111; res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_grant: got %b exp 0100", req_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (res_id !== 2'd2 || res_sum !== 18'd23) begin errors++; $display("FAIL bp_first_result: got id=%0d sum=%0d exp id=2 sum=23", res_id, res_sum); end
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            res_ready = 1'b0;
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b exp 0000", s, req_ready); end
            @(posedge clk);
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_sum !== 18'd23 || res_id !== 2'd2 || busy_cycles !== 16'(s))
                begin errors++; $display("FAIL bp_stall_hold[%0d]: got v=%b sum=%0d id=%0d busy=%0d exp v=1 sum=23 id=2 busy=%0d", s, res_valid, res_sum, res_id, busy_cycles, s); end
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_resume_grant: got %b exp 1000", req_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (res_id !== 2'd3 || res_sum !== 18'd34 || busy_cycles !== 16'd5)
            begin errors++; $display("FAIL bp_resume_result: got id=%0d sum=%0d busy=%0d exp id=3 sum=34 busy=5", res_id, res_sum, busy_cycles); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy_cycles !== 16'd5) begin errors++; $display("FAIL bp_drain: got v=%b busy=%0d exp v=0 busy=5", res_valid, busy_cycles); end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        req_valid = 4'b0010; res_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (res_id !== 2'd1 || res_sum !== 18'd12) begin errors++; $display("FAIL mid_pending: got id=%0d sum=%0d exp id=1 sum=12", res_id, res_sum); end
        @(negedge clk);
        res_ready = 1'b0; req_valid = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0000", req_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_id !== 2'd0 || res_sum !== 18'd0 || busy_cycles !== 16'd0)
            begin errors++; $display("FAIL mid_rst_state: got v=%b id=%0d sum=%0d busy=%0d exp all 0", res_valid, res_id, res_sum, busy_cycles); end
        @(negedge clk);
        rst = 1'b0; res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_reset: got %b exp 0001", req_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_sum !== 18'd1)
            begin errors++; $display("FAIL mid_after_rst: got v=%b id=%0d sum=%0d exp v=1 id=0 sum=1", res_valid, res_id, res_sum); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = 4'b0000; res_ready = 1'b1;
        req_a = 68'd0; req_b = 68'd0;
        test_reset();
        test_single_lane();
        test_round_robin();
        test_extremes();
        test_back_pressure();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
